// File: rtl/rf_pkg.sv
// Shared defaults and packed-field helpers for the bypassing register file.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  // Low bit index of field idx inside a packed vector of w-bit fields.
  function automatic int unsigned fld_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writeback bits, a registered pending counter and
// per-read-port RAW busy flags for the decode stage.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             resv_ok, set_new, clr_old;

  // A reservation wins over a same-cycle writeback to the same register.
  always_comb begin
    resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));
    set_new = resv_ok && !pend_q[resv_addr];
    clr_old = wr_en && pend_q[wr_addr] && !(resv_ok && (resv_addr == wr_addr));
    pend_d  = pend_q;
    if (wr_en)   pend_d[wr_addr]   = 1'b0;
    if (resv_ok) pend_d[resv_addr] = 1'b1;
    cnt_d = cnt_q;
    if (set_new && !clr_old)      cnt_d = cnt_q + CNT_ONE;
    else if (clr_old && !set_new) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  // A writeback landing this cycle satisfies the hazard.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a          = rd_addr[fld_lo(i, ADDR_W) +: ADDR_W];
    assign rd_busy[i] = pend_q[a] && !(wr_en && (wr_addr == a));
  end

endmodule

// File: rtl/rf_bypass_sb.sv
// Multi-read-port register file with write-to-read bypass and a writeback
// scoreboard for RAW hazard detection.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  output logic [ADDR_W:0]          pend_cnt,
  input  logic                     hlt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic              unused_hlt;

  // The register dump request is a simulation aid and carries no logic.
  assign unused_hlt = hlt;
  assign wr_ok      = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_d, rd_q;

    assign addr = rd_addr[fld_lo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      rd_d = rd_q;
      if (rd_en[i]) begin
        if ((ZERO_REG != 0) && (addr == '0))   rd_d = '0;
        else if (wr_en && (wr_addr == addr))   rd_d = wr_data;
        else                                   rd_d = mem_q[addr];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_d;
    end

    assign rd_data[fld_lo(i, DATA_W) +: DATA_W] = rd_q;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .rd_busy   (rd_busy),
    .pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Vector table plus hand sequences; expected read data and counts are queued
// when a vector is driven and checked after the clock edge.
module tb_rf_bypass_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_en;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        resv_en;
  logic [3:0]  resv_addr;
  logic [4:0]  pend_cnt;
  logic        hlt;

  rf_bypass_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .pend_cnt  (pend_cnt),
    .hlt       (hlt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  re;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rv;
    logic [3:0]  ra;
    logic [1:0]  busy;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [4:0]  cnt;
  } vec_t;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [4:0]  cnt;
  } exp_t;

  exp_t        q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] hold0  = '0;
  logic [15:0] hold1  = '0;
  vec_t        tbl[14];

  function automatic vec_t mk(input logic [1:0] re, input logic [3:0] a0, input logic [3:0] a1,
                              input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic rv, input logic [3:0] ra, input logic [1:0] busy,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [4:0] cnt);
    vec_t v;
    v.re = re; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra; v.busy = busy; v.d0 = d0; v.d1 = d1; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      n_miss++;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rd_en = v.re; rd_addr = {v.a1, v.a0};
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    resv_en = v.rv; resv_addr = v.ra;
    #1;
    check("rd_busy", 32'(rd_busy), 32'(v.busy));
    if (v.re[0]) hold0 = v.d0;
    if (v.re[1]) hold1 = v.d1;
    e.d0 = hold0; e.d1 = hold1; e.cnt = v.cnt;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    check("rd_data0", 32'(rd_data[15:0]), 32'(e.d0));
    check("rd_data1", 32'(rd_data[31:16]), 32'(e.d1));
    check("pend_cnt", 32'(pend_cnt), 32'(e.cnt));
    n_vec++;
  endtask

  initial begin
    //              re     a0 a1 we wa wd        rv ra busy   d0        d1        cnt
    tbl[0]  = mk(2'b00, 0, 0, 1, 3, 16'h1234, 0, 0, 2'b00, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(2'b11, 3, 3, 0, 0, 16'h0000, 0, 0, 2'b00, 16'h1234, 16'h1234, 0);
    tbl[2]  = mk(2'b10, 3, 7, 1, 7, 16'hA5A5, 0, 0, 2'b00, 16'h0000, 16'hA5A5, 0);
    tbl[3]  = mk(2'b11, 0, 0, 1, 0, 16'hFFFF, 1, 0, 2'b00, 16'h0000, 16'h0000, 0);
    tbl[4]  = mk(2'b00, 2, 2, 0, 0, 16'h0000, 1, 2, 2'b00, 16'h0000, 16'h0000, 1);
    tbl[5]  = mk(2'b11, 2, 4, 0, 0, 16'h0000, 1, 4, 2'b01, 16'h0000, 16'h0000, 2);
    tbl[6]  = mk(2'b11, 2, 4, 0, 0, 16'h0000, 0, 0, 2'b11, 16'h0000, 16'h0000, 2);
    tbl[7]  = mk(2'b11, 2, 4, 1, 2, 16'h2222, 0, 0, 2'b10, 16'h2222, 16'h0000, 1);
    tbl[8]  = mk(2'b01, 9, 4, 1, 9, 16'h9999, 1, 9, 2'b10, 16'h9999, 16'h0000, 2);
    tbl[9]  = mk(2'b01, 9, 4, 0, 0, 16'h0000, 1, 9, 2'b11, 16'h9999, 16'h0000, 2);
    tbl[10] = mk(2'b00, 4, 9, 1, 4, 16'h4444, 1, 9, 2'b10, 16'h0000, 16'h0000, 1);
    tbl[11] = mk(2'b11, 9, 6, 1, 9, 16'h1111, 1, 6, 2'b00, 16'h1111, 16'h0000, 1);
    tbl[12] = mk(2'b11, 2, 6, 1, 2, 16'h5555, 0, 0, 2'b10, 16'h5555, 16'h0000, 1);
    tbl[13] = mk(2'b11, 4, 3, 0, 0, 16'h0000, 0, 0, 2'b00, 16'h4444, 16'h1234, 1);

    rst_n = 1'b0; hlt = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0;
    repeat (2) @(negedge clk);
    check("reset rd_data", rd_data, 32'h0);
    check("reset pend_cnt", 32'(pend_cnt), 32'd0);
    check("reset rd_busy", 32'(rd_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset lands in the middle of a write and reservation of R5.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    resv_en = 1'b1; resv_addr = 4'd5;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midreset pend_cnt", 32'(pend_cnt), 32'd0);
    rst_n = 1'b1;
    hold0 = '0; hold1 = '0;
    apply(mk(2'b01, 5, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0));

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Clear R6, then reserve every non-zero register.
    apply(mk(2'b00, 0, 0, 1, 6, 16'h6666, 0, 0, 2'b00, 16'h0, 16'h0, 0));
    for (int r = 1; r < 16; r++)
      apply(mk(2'b00, 0, 0, 0, 0, 16'h0, 1, 4'(r), 2'b00, 16'h0, 16'h0, 5'(r)));
    apply(mk(2'b00, 0, 0, 0, 0, 16'h0, 1, 0, 2'b00, 16'h0, 16'h0, 15));
    apply(mk(2'b11, 15, 1, 0, 0, 16'h0, 0, 0, 2'b11, 16'h0000, 16'h0000, 15));

    // Retire them one by one, reading each through the bypass path.
    for (int r = 1; r < 16; r++)
      apply(mk(2'b01, 4'(r), 0, 1, 4'(r), 16'(r * 16'h0101), 0, 0, 2'b00,
               16'(r * 16'h0101), 16'h0, 5'(15 - r)));
    apply(mk(2'b11, 15, 6, 0, 0, 16'h0, 0, 0, 2'b00, 16'h0F0F, 16'h0606, 0));

    hlt = 1'b1;
    @(negedge clk);
    check("hlt pend_cnt", 32'(pend_cnt), 32'd0);
    check("hlt rd_data", rd_data, 32'h0606_0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
